reg_bank_arbiter: RTL and testbench

- Round-robin arbiter that shares one write port of a DFF-based register bank among NREQ requesters.
- Each requester wins ownership, writes a burst of beats, and then releases the port.
- The arbiter enforces a maximum burst length and owns the bank storage.
- Reads are through an independent, unarbitrated port; this block sits between requesters and the bank.

---
 rtl/reg_bank_arbiter_pkg.sv | 15 +
 rtl/reg_bank_arbiter_if.sv | 29 ++
 rtl/reg_bank_arbiter_rr_pick.sv | 32 +++
 rtl/reg_bank_arbiter.sv | 118 +++++++++++
 tb/tb_reg_bank_arbiter.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/reg_bank_arbiter_pkg.sv
// Shared types and default sizing for the register-bank write arbiter.
package reg_bank_arbiter_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      OWN  = 1'b1
   } state_t;

   localparam int unsigned NREQ_DEF     = 4;
   localparam int unsigned DW_DEF       = 8;
   localparam int unsigned AW_DEF       = 2;
   localparam int unsigned MAXBURST_DEF = 4;
   localparam int unsigned CNT_W        = 4;

endpackage

// File: rtl/reg_bank_arbiter_if.sv
// Requester-side write bus plus the unarbitrated read port of the register bank.
interface reg_bank_arbiter_if
   import reg_bank_arbiter_pkg::*;
#(
   parameter int unsigned NREQ = NREQ_DEF,
   parameter int unsigned DW   = DW_DEF,
   parameter int unsigned AW   = AW_DEF
);
   logic [NREQ-1:0]    req;
   logic [NREQ-1:0]    req_last;
   logic [NREQ*AW-1:0] req_addr;
   logic [NREQ*DW-1:0] req_data;
   logic [NREQ-1:0]    gnt;
   logic [NREQ-1:0]    ack;
   logic               err;
   logic               busy;
   logic [AW-1:0]      rd_addr;
   logic [DW-1:0]      rd_data;

   modport slave (
      input  req, req_last, req_addr, req_data, rd_addr,
      output gnt, ack, err, busy, rd_data
   );

   modport master (
      output req, req_last, req_addr, req_data, rd_addr,
      input  gnt, ack, err, busy, rd_data
   );
endinterface

// File: rtl/reg_bank_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping modulo NREQ.
module rr_pick #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IW   = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] onehot,
   output logic [IW-1:0]   idx,
   output logic            valid
);
   int unsigned   j;
   logic [IW-1:0] jj;

   always_comb begin
      onehot = '0;
      idx    = '0;
      valid  = 1'b0;
      j      = 0;
      jj     = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         j = 32'(ptr) + i;
         if (j >= NREQ) j = j - NREQ;
         jj = j[IW-1:0];
         if (!valid && req[jj]) begin
            valid      = 1'b1;
            onehot[jj] = 1'b1;
            idx        = jj;
         end
      end
   end
endmodule

// File: rtl/reg_bank_arbiter.sv
// Round-robin owner of a DFF register bank write port with bounded bursts.
module reg_bank_arbiter
   import reg_bank_arbiter_pkg::*;
#(
   parameter int unsigned NREQ     = NREQ_DEF,
   parameter int unsigned DW       = DW_DEF,
   parameter int unsigned AW       = AW_DEF,
   parameter int unsigned MAXBURST = MAXBURST_DEF
) (
   input  logic            clk,
   input  logic            rst,
   reg_bank_arbiter_if.slave bus
);
   localparam int unsigned        IW       = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned        DEPTH    = 2 ** AW;
   localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(MAXBURST - 1);

   state_t            state_q, state_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic [NREQ-1:0]   ack_q, ack_d;
   logic              err_q, err_d;
   logic [IW-1:0]     ptr_q, ptr_d;
   logic [IW-1:0]     own_q, own_d;
   logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
   logic [DW-1:0]     bank_q [DEPTH];
   logic [DW-1:0]     bank_d [DEPTH];

   logic [NREQ-1:0]   pick_onehot;
   logic [IW-1:0]     pick_idx;
   logic              pick_valid;
   logic              beat, own_last, rel;
   logic [AW-1:0]     own_addr;
   logic [DW-1:0]     own_data;

   rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
      .req    (bus.req),
      .ptr    (ptr_q),
      .onehot (pick_onehot),
      .idx    (pick_idx),
      .valid  (pick_valid)
   );

   assign beat     = gnt_q[own_q] & bus.req[own_q];
   assign own_last = bus.req_last[own_q];
   assign own_addr = AW'(bus.req_addr >> (32'(own_q) * AW));
   assign own_data = DW'(bus.req_data >> (32'(own_q) * DW));

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      ack_d      = '0;
      err_d      = 1'b0;
      ptr_d      = ptr_q;
      own_d      = own_q;
      beat_cnt_d = beat_cnt_q;
      bank_d     = bank_q;
      rel        = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_valid) begin
               state_d    = OWN;
               gnt_d      = pick_onehot;
               own_d      = pick_idx;
               beat_cnt_d = '0;
            end
         end
         OWN: begin
            if (!beat) begin
               rel = 1'b1;
            end else begin
               bank_d[own_addr] = own_data;
               ack_d[own_q]     = 1'b1;
               beat_cnt_d       = beat_cnt_q + 1'b1;
               if (own_last) begin
                  rel = 1'b1;
               end else if (beat_cnt_q == LAST_CNT) begin
                  rel   = 1'b1;
                  err_d = 1'b1;
               end
            end
         end
      endcase
      // Every release path hands priority to the requester after the owner.
      if (rel) begin
         state_d = IDLE;
         gnt_d   = '0;
         ptr_d   = (own_q == IW'(NREQ - 1)) ? '0 : own_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         gnt_q      <= '0;
         ack_q      <= '0;
         err_q      <= 1'b0;
         ptr_q      <= '0;
         own_q      <= '0;
         beat_cnt_q <= '0;
         bank_q     <= '{default: '0};
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         ack_q      <= ack_d;
         err_q      <= err_d;
         ptr_q      <= ptr_d;
         own_q      <= own_d;
         beat_cnt_q <= beat_cnt_d;
         bank_q     <= bank_d;
      end
   end

   assign bus.gnt     = gnt_q;
   assign bus.ack     = ack_q;
   assign bus.err     = err_q;
   assign bus.busy    = (state_q == OWN);
   assign bus.rd_data = bank_q[bus.rd_addr];
endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed bench for reg_bank_arbiter: reset, bursts, fairness, forced release, abort, mid-burst reset.
module tb_reg_bank_arbiter;
   localparam int unsigned NREQ = 4;
   localparam int unsigned DW   = 8;
   localparam int unsigned AW   = 2;

   logic clk;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   reg_bank_arbiter_if #(.NREQ(NREQ), .DW(DW), .AW(AW)) bus ();

   reg_bank_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW), .MAXBURST(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rd_chk(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] e);
      bus.rd_addr = a;
      #1;
      chk(tag, 32'(bus.rd_data), 32'(e));
   endtask

   task automatic drive(input int unsigned i, input logic r, input logic l,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
      bus.req[i]              = r;
      bus.req_last[i]         = l;
      bus.req_addr[i*AW +: AW] = a;
      bus.req_data[i*DW +: DW] = d;
   endtask

   task automatic drop_all();
      for (int unsigned i = 0; i < NREQ; i++) drive(i, 1'b0, 1'b0, '0, '0);
   endtask

   int unsigned order [5];

   initial begin
      rst         = 1'b0;
      bus.req     = '0;
      bus.req_last = '0;
      bus.req_addr = '0;
      bus.req_data = '0;
      bus.rd_addr = '0;
      for (int unsigned i = 0; i < NREQ; i++) drive(i, 1'b1, 1'b0, '0, '0);

      // reset with every requester asking
      step();
      chk("rst_gnt", 32'(bus.gnt), 32'h0);
      chk("rst_busy", 32'(bus.busy), 32'h0);
      chk("rst_ack", 32'(bus.ack), 32'h0);
      chk("rst_err", 32'(bus.err), 32'h0);
      for (int unsigned a = 0; a < 4; a++) rd_chk("rst_rd", AW'(a), 8'h00);
      step();
      chk("rst_gnt2", 32'(bus.gnt), 32'h0);
      rst = 1'b1;
      step();
      chk("first_gnt", 32'(bus.gnt), 32'b0001);
      chk("first_busy", 32'(bus.busy), 32'h1);

      // single two-beat burst from requester 0
      for (int unsigned i = 1; i < NREQ; i++) drive(i, 1'b0, 1'b0, '0, '0);
      drive(0, 1'b1, 1'b0, 2'd0, 8'hA5);
      step();
      chk("sb_ack1", 32'(bus.ack), 32'b0001);
      chk("sb_gnt1", 32'(bus.gnt), 32'b0001);
      rd_chk("sb_rd0", 2'd0, 8'hA5);
      drive(0, 1'b1, 1'b1, 2'd1, 8'h3C);
      step();
      chk("sb_ack2", 32'(bus.ack), 32'b0001);
      chk("sb_gnt2", 32'(bus.gnt), 32'h0);
      chk("sb_busy2", 32'(bus.busy), 32'h0);
      chk("sb_err", 32'(bus.err), 32'h0);
      rd_chk("sb_rd1", 2'd1, 8'h3C);
      drop_all();
      step();
      chk("sb_ack3", 32'(bus.ack), 32'h0);
      chk("sb_gnt3", 32'(bus.gnt), 32'h0);

      // fairness: ptr is 1 after requester 0 released
      order = '{1, 2, 3, 0, 1};
      for (int unsigned i = 0; i < NREQ; i++) drive(i, 1'b1, 1'b1, AW'(i), 8'h10 + DW'(i));
      for (int unsigned k = 0; k < 5; k++) begin
         step();
         chk("rr_gnt", 32'(bus.gnt), 32'(1) << order[k]);
         chk("rr_ack_idle", 32'(bus.ack), 32'h0);
         if (k < 4) begin
            step();
            chk("rr_gap_gnt", 32'(bus.gnt), 32'h0);
            chk("rr_ack", 32'(bus.ack), 32'(1) << order[k]);
         end
      end
      drop_all();
      step();
      chk("rr_abort_gnt", 32'(bus.gnt), 32'h0);
      chk("rr_abort_ack", 32'(bus.ack), 32'h0);
      rd_chk("rr_rd0", 2'd0, 8'h10);
      rd_chk("rr_rd1", 2'd1, 8'h11);
      rd_chk("rr_rd2", 2'd2, 8'h12);
      rd_chk("rr_rd3", 2'd3, 8'h13);

      // forced release: requester 2 streams without last, requester 3 waits
      drive(2, 1'b1, 1'b0, 2'd3, 8'd1);
      drive(3, 1'b1, 1'b1, 2'd0, 8'h99);
      step();
      chk("fr_gnt", 32'(bus.gnt), 32'b0100);
      for (int unsigned b = 1; b < 4; b++) begin
         step();
         chk("fr_ack", 32'(bus.ack), 32'b0100);
         chk("fr_gnt_hold", 32'(bus.gnt), 32'b0100);
         chk("fr_err_low", 32'(bus.err), 32'h0);
         drive(2, 1'b1, 1'b0, 2'd3, DW'(b + 1));
      end
      step();
      chk("fr_rel_gnt", 32'(bus.gnt), 32'h0);
      chk("fr_rel_ack", 32'(bus.ack), 32'b0100);
      chk("fr_err", 32'(bus.err), 32'h1);
      drive(2, 1'b1, 1'b0, 2'd3, 8'd5);
      step();
      chk("fr_next_gnt", 32'(bus.gnt), 32'b1000);
      chk("fr_no_ack", 32'(bus.ack), 32'h0);
      chk("fr_err_once", 32'(bus.err), 32'h0);
      rd_chk("fr_rd3", 2'd3, 8'd4);
      drive(2, 1'b1, 1'b0, 2'd3, 8'd6);
      step();
      chk("fr_r3_ack", 32'(bus.ack), 32'b1000);
      chk("fr_r3_gnt", 32'(bus.gnt), 32'h0);
      drop_all();
      rd_chk("fr_rd0", 2'd0, 8'h99);
      rd_chk("fr_rd3b", 2'd3, 8'd4);

      // abort: requester 1 writes once then drops req (ptr is 0 here)
      drive(1, 1'b1, 1'b0, 2'd2, 8'h77);
      step();
      chk("ab_gnt", 32'(bus.gnt), 32'b0010);
      step();
      chk("ab_ack", 32'(bus.ack), 32'b0010);
      chk("ab_gnt_hold", 32'(bus.gnt), 32'b0010);
      rd_chk("ab_rd2", 2'd2, 8'h77);
      drop_all();
      step();
      chk("ab_rel_gnt", 32'(bus.gnt), 32'h0);
      chk("ab_rel_ack", 32'(bus.ack), 32'h0);
      chk("ab_rel_err", 32'(bus.err), 32'h0);
      chk("ab_rel_busy", 32'(bus.busy), 32'h0);
      for (int unsigned i = 0; i < NREQ; i++) drive(i, 1'b1, 1'b1, 2'd0, 8'h00);
      step();
      chk("ab_ptr_gnt", 32'(bus.gnt), 32'b0100);
      drop_all();
      step();
      chk("ab2_gnt", 32'(bus.gnt), 32'h0);
      chk("ab2_ack", 32'(bus.ack), 32'h0);

      // reset during beat 2 of a 3-beat burst
      drive(0, 1'b1, 1'b0, 2'd1, 8'h55);
      step();
      chk("mr_gnt", 32'(bus.gnt), 32'b0001);
      step();
      chk("mr_ack1", 32'(bus.ack), 32'b0001);
      drive(0, 1'b1, 1'b0, 2'd2, 8'h66);
      rst = 1'b0;
      #1;
      chk("mr_gnt_drop", 32'(bus.gnt), 32'h0);
      chk("mr_busy", 32'(bus.busy), 32'h0);
      chk("mr_ack_clr", 32'(bus.ack), 32'h0);
      for (int unsigned a = 0; a < 4; a++) rd_chk("mr_rd", AW'(a), 8'h00);
      step();
      drop_all();
      rst = 1'b1;
      step();
      chk("mr_post_gnt", 32'(bus.gnt), 32'h0);
      chk("mr_post_ack", 32'(bus.ack), 32'h0);
      chk("mr_post_err", 32'(bus.err), 32'h0);
      step();
      chk("mr_post_ack2", 32'(bus.ack), 32'h0);
      chk("mr_post_err2", 32'(bus.err), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
